// File: rtl/ibuf_east.sv
// East-port input buffer: flit FIFO plus a wormhole FSM that latches the
// route request on each header and drops unroutable or orphan packets.
module ibuf_east #(
   parameter int FLIT_W = 8,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLIT_W-1:0] in_flit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [FLIT_W-1:0] out_flit,
   output logic              out_valid,
   input  logic [4:0]        route_in,
   output logic [4:0]        port_req,
   input  logic              grant,
   output logic              drop_err,
   output logic [PTR_W:0]    count
);

   typedef enum logic [1:0] {IDLE, REQ, ACTIVE, DROP} state_e;

   localparam logic [1:0]   T_HDR  = 2'b10;
   localparam logic [1:0]   T_TAIL = 2'b01;
   localparam logic [1:0]   T_SGL  = 2'b11;
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q, count_d;
   state_e            state_q, state_d;
   logic [4:0]        port_req_q, port_req_d;
   logic              drop_err_q, drop_err_d;
   logic              push, pop;
   logic [1:0]        head_type;
   logic              route_ok;

   assign in_ready  = (count_q < FULL);
   assign out_valid = (count_q != '0);
   assign out_flit  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign push      = in_valid && in_ready;
   assign head_type = mem_q[rd_ptr_q][FLIT_W-1:FLIT_W-2];
   assign route_ok  = (route_in != 5'd0) && ((route_in & (route_in - 5'd1)) == 5'd0);

   assign port_req = port_req_q;
   assign drop_err = drop_err_q;
   assign count    = count_q;

   always_comb begin
      state_d    = state_q;
      port_req_d = port_req_q;
      drop_err_d = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (out_valid) begin
               if (head_type == T_HDR || head_type == T_SGL) begin
                  if (route_ok) begin
                     port_req_d = route_in;
                     state_d    = REQ;
                  end else begin
                     pop        = 1'b1;
                     drop_err_d = 1'b1;
                     state_d    = (head_type == T_HDR) ? DROP : IDLE;
                  end
               end else begin
                  pop        = 1'b1;
                  drop_err_d = 1'b1;
               end
            end
         end
         REQ: begin
            if (grant && out_valid) begin
               pop = 1'b1;
               if (head_type == T_SGL) begin
                  port_req_d = 5'd0;
                  state_d    = IDLE;
               end else begin
                  state_d = ACTIVE;
               end
            end
         end
         ACTIVE: begin
            // Only a true tail closes the worm; stray headers pass as body.
            if (grant && out_valid) begin
               pop = 1'b1;
               if (head_type == T_TAIL) begin
                  port_req_d = 5'd0;
                  state_d    = IDLE;
               end
            end
         end
         DROP: begin
            if (out_valid) begin
               pop = 1'b1;
               if (head_type == T_TAIL) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         port_req_q <= 5'd0;
         drop_err_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         state_q    <= state_d;
         port_req_q <= port_req_d;
         drop_err_q <= drop_err_d;
      end
   end

   // Storage is never reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_flit;
   end

endmodule

// File: tb/tb_ibuf_east.sv
// Directed bench for ibuf_east: wormhole routing, backpressure, drops, reset.
module tb_ibuf_east;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_flit;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_flit;
   logic       out_valid;
   logic [4:0] route_in;
   logic [4:0] port_req;
   logic       grant;
   logic       drop_err;
   logic [2:0] count;

   int n_chk = 0;
   int n_err = 0;

   ibuf_east dut (
      .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(in_ready), .out_flit(out_flit), .out_valid(out_valid),
      .route_in(route_in), .port_req(port_req), .grant(grant),
      .drop_err(drop_err), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push1(input logic [7:0] f);
      in_flit  = f;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] t2v [5];
      t2v[0] = 8'h81; t2v[1] = 8'h11; t2v[2] = 8'h12; t2v[3] = 8'h43; t2v[4] = 8'h14;

      rst_n = 1'b0; in_flit = '0; in_valid = 1'b0; route_in = '0; grant = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_count", count, 0);
      chk("rst_ovalid", out_valid, 0);
      chk("rst_preq", port_req, 0);
      chk("rst_iready", in_ready, 1);
      chk("rst_drop", drop_err, 0);
      chk("rst_oflit", out_flit, 0);

      // T1: hdr/body/tail routed east
      route_in = 5'b00010;
      push1(8'h83);
      chk("t1_head", out_flit, 8'h83);
      chk("t1_preq_early", port_req, 0);
      push1(8'h15);
      chk("t1_preq", port_req, 5'b00010);
      chk("t1_cnt2", count, 2);
      push1(8'h42);
      chk("t1_cnt3", count, 3);
      grant = 1'b1;
      tick();
      chk("t1_pop1_cnt", count, 2);
      chk("t1_pop1_head", out_flit, 8'h15);
      tick();
      chk("t1_pop2_head", out_flit, 8'h42);
      chk("t1_preq_held", port_req, 5'b00010);
      tick();
      chk("t1_preq_clr", port_req, 0);
      chk("t1_empty", out_valid, 0);
      grant = 1'b0;

      // T2: fill to full with no grant; 5th flit held off
      route_in = 5'b00100;
      for (int i = 0; i < 5; i++) begin
         in_flit  = t2v[i];
         in_valid = 1'b1;
         tick();
         if (i == 3) chk("t2_iready_full", in_ready, 0);
      end
      in_valid = 1'b0;
      chk("t2_cnt", count, 4);
      chk("t2_head", out_flit, 8'h81);
      grant = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      grant = 1'b0;
      chk("t2_drained", count, 0);
      chk("t2_preq_clr", port_req, 0);

      // T3: single-flit packet
      route_in = 5'b00001;
      push1(8'hC5);
      tick();
      chk("t3_preq", port_req, 5'b00001);
      grant = 1'b1;
      tick();
      grant = 1'b0;
      chk("t3_preq_clr", port_req, 0);
      chk("t3_cnt", count, 0);

      // T4: unroutable header dropped with its body and tail, no grant
      route_in = 5'b00000;
      push1(8'h80);
      push1(8'h10);
      chk("t4_drop_pulse", drop_err, 1);
      chk("t4_cnt_a", count, 1);
      push1(8'h40);
      chk("t4_drop_low", drop_err, 0);
      tick();
      chk("t4_cnt", count, 0);
      chk("t4_drop_low2", drop_err, 0);
      chk("t4_preq", port_req, 0);

      // T5: simultaneous push and pop in ACTIVE
      route_in = 5'b01000;
      push1(8'h82);
      push1(8'h21);
      push1(8'h22);
      grant = 1'b1;
      tick();
      chk("t5_cnt_active", count, 2);
      chk("t5_head_a", out_flit, 8'h21);
      in_flit = 8'h44; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t5_cnt_same", count, 2);
      chk("t5_head_b", out_flit, 8'h22);
      tick();
      chk("t5_head_c", out_flit, 8'h44);
      tick();
      grant = 1'b0;
      chk("t5_done_cnt", count, 0);
      chk("t5_done_preq", port_req, 0);

      // T6: reset mid-packet, then orphan body is dropped
      route_in = 5'b00010;
      push1(8'h83);
      push1(8'h15);
      push1(8'h16);
      push1(8'h17);
      grant = 1'b1;
      tick();
      grant = 1'b0;
      chk("t6_cnt3", count, 3);
      chk("t6_preq", port_req, 5'b00010);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_ovalid", out_valid, 0);
      chk("t6_cnt", count, 0);
      chk("t6_preq_clr", port_req, 0);
      chk("t6_iready", in_ready, 1);
      push1(8'h18);
      chk("t6_orphan_cnt", count, 1);
      tick();
      chk("t6_orphan_drop", drop_err, 1);
      chk("t6_orphan_gone", count, 0);
      tick();
      chk("t6_drop_low", drop_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
